// File: rtl/count_sched_pkg.sv
// count_sched_pkg: shared types and helpers for the round-robin count scheduler.
//   state_e : scheduler FSM states (idle, counting, one-cycle completion)
//   DefCw   : default counter width, matching the 4-bit counter datapath
//   id_w()  : width of a requester id for a given requester count
package count_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCount,
    StDone
  } state_e;

  localparam int unsigned DefCw = 4;

  // Never returns 0 so an id always has at least one bit.
  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/count_sched_if.sv
// count_sched_if: request/grant/counter bundle between requesters and count_sched.
//   req     : per-requester run request (level)
//   len     : packed terminal values, slice i = len[i*CW +: CW]
//   x       : count enable
//   gnt     : one-hot grant
//   busy    : run owned
//   cnt     : shared counter value
//   done    : one-cycle end-of-run pulse
//   done_id : id of finished owner
//   abort   : one-cycle abort pulse (only when CNT_ABORT_EN is defined)
// Modports: slave = scheduler side, master = requester side.
interface count_sched_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned CW   = 4
) ();

  localparam int unsigned IdW = count_sched_pkg::id_w(NREQ);

  logic [NREQ-1:0]    req;
  logic [NREQ*CW-1:0] len;
  logic               x;
  logic [NREQ-1:0]    gnt;
  logic               busy;
  logic [CW-1:0]      cnt;
  logic               done;
  logic [IdW-1:0]     done_id;
`ifdef CNT_ABORT_EN
  logic               abort;
`endif

  modport slave (
    input  req, len, x,
`ifdef CNT_ABORT_EN
    output abort,
`endif
    output gnt, busy, cnt, done, done_id
  );

  modport master (
    output req, len, x,
`ifdef CNT_ABORT_EN
    input  abort,
`endif
    input  gnt, busy, cnt, done, done_id
  );

endinterface

// File: rtl/count_sched_rr_pick.sv
// rr_pick: combinational round-robin search.
//   req : request vector
//   ptr : search start position
//   any : at least one request set
//   id  : first set request at or above ptr, wrapping at NREQ
module rr_pick
  import count_sched_pkg::*;
#(
  parameter int unsigned  NREQ = 4,
  localparam int unsigned IdW  = id_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IdW-1:0]  ptr,
  output logic            any,
  output logic [IdW-1:0]  id
);

  int unsigned idx;

  always_comb begin
    any = 1'b0;
    id  = '0;
    idx = 0;
    for (int k = 0; k < int'(NREQ); k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!any && req[idx]) begin
        any = 1'b1;
        id  = IdW'(idx);
      end
    end
  end

endmodule

// File: rtl/count_sched.sv
// count_sched: round-robin scheduler sharing one up-counter between NREQ requesters.
// Grants one requester at a time, counts under enable x up to the owner's latched
// terminal value, pulses done with the owner id, then re-arbitrates.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high reset
//   bus   : count_sched_if slave (req/len/x in; gnt/busy/cnt/done/done_id out)
// Build option CNT_ABORT_EN: owner dropping req mid-run aborts the run (abort pulse).
// All outputs come straight from registers.
module count_sched
  import count_sched_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned CW   = DefCw
) (
  input logic           clk,
  input logic           reset,
  count_sched_if.slave  bus
);

  localparam int unsigned IdW = id_w(NREQ);

  state_e          state_q, state_d;
  logic [IdW-1:0]  ptr_q, ptr_d;
  logic [IdW-1:0]  owner_q, owner_d;
  logic [CW-1:0]   tgt_q, tgt_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [IdW-1:0]  done_id_q, done_id_d;
  logic            abort_q, abort_d;

  logic            pick_any;
  logic [IdW-1:0]  pick_id;
  logic [IdW-1:0]  ptr_next;

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req (bus.req),
    .ptr (ptr_q),
    .any (pick_any),
    .id  (pick_id)
  );

  assign ptr_next = (owner_q == IdW'(NREQ - 1)) ? '0 : owner_q + IdW'(1);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    tgt_d     = tgt_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    abort_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          state_d = StCount;
          owner_d = pick_id;
          tgt_d   = bus.len[int'(pick_id) * CW +: CW];
          cnt_d   = '0;
          gnt_d   = {{(NREQ - 1){1'b0}}, 1'b1} << pick_id;
          busy_d  = 1'b1;
        end
      end
      StCount: begin
        // Terminal compare wins over enable, so cnt never passes tgt.
        if (cnt_q == tgt_q) begin
          state_d   = StDone;
          gnt_d     = '0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          done_id_d = owner_q;
        end
`ifdef CNT_ABORT_EN
        else if (!bus.req[owner_q]) begin
          state_d = StIdle;
          gnt_d   = '0;
          busy_d  = 1'b0;
          abort_d = 1'b1;
          ptr_d   = ptr_next;
        end
`endif
        else if (bus.x) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
        ptr_d   = ptr_next;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      owner_q   <= '0;
      tgt_q     <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      tgt_q     <= tgt_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      abort_q   <= abort_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.busy    = busy_q;
  assign bus.cnt     = cnt_q;
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;
`ifdef CNT_ABORT_EN
  assign bus.abort   = abort_q;
`else
  logic unused_abort;
  assign unused_abort = abort_q;
`endif

endmodule
